fifo_wptr_full_n: RTL and testbench
===================================

# fifo_wptr_full_n

Write-side pointer and full-flag generator for the UART async FIFOs. It keeps the binary write pointer and publishes it as a registered Gray-code pointer for crossing into the read clock domain. It synchronizes the read domain's Gray pointer into the write domain and decodes it back to binary. From that it produces a registered `full` flag and a fill-level estimate. It is the encoding and write-end counterpart of the read-side Gray-to-binary pointer logic.

## Interface
Parameters:
- `n`, default 4: FIFO address width. Depth is 2^n. Pointers are n+1 bits. Legal n ≥ 1.

Ports:
- `clk`, in, 1: write-domain clock.
- `rst_n`, in, 1: synchronous reset, active-low. One clock; reset is synchronous and active-low.
- `wr_en`, in, 1: write request for this cycle.
- `rd_ptr_g`, in, n+1: read pointer in Gray code from the read domain. It is asynchronous to `clk`.
- `wr_ack`, out, 1: write accepted this cycle. Combinational: `wr_en & ~full`.
- `wr_addr`, out, n: RAM write address, equal to `wr_bin[n-1:0]`. Registered.
- `wr_ptr_g`, out, n+1: Gray write pointer for the read domain. Registered and glitch-free.
- `full`, out, 1: FIFO full. Registered.
- `wr_level`, out, n+1: words in FIFO as seen from the write domain. Range 0..2^n.

## Operation
- **Internal state:**
  - `wr_bin[n:0]`: binary write pointer.
  - `wr_ptr_g[n:0]`.
  - `rs1`, `rs2[n:0]`: two-flop synchronizer on `rd_ptr_g`.
  - `full`.
- **Accept rule:** a write is accepted when `wr_en=1` and `full=0`. On acceptance, `wr_bin` increments by 1 at the clock edge.
- **Wrap:** the increment is modulo 2^(n+1). The wrap from all-ones to 0 is legal and continuous.
- **Next-state Gray:**
  - `wr_bin_next = wr_bin + wr_ack`.
  - `wr_g_next = wr_bin_next ^ (wr_bin_next >> 1)`.
  - `wr_ptr_g` is loaded from `wr_g_next` each cycle. Exactly one bit changes per accepted write.
- **Full:**
  - Registered value is `full <= (wr_g_next == {~rs2[n], ~rs2[n-1], rs2[n-2:0]})`.
  - For n=1 the comparison is `{~rs2[1], ~rs2[0]}`.
- **Write while full:** ignored. `wr_ack=0` and all pointers hold. There is no error flag.
- **Level:**
  - `rd_bin_s` is the Gray-to-binary decode of `rs2`, using prefix XOR from the MSB.
  - `wr_level = (wr_bin - rd_bin_s) mod 2^(n+1)`.
  - Combinational from registers; no glitch requirement.
- **Synchronizer:** `rs1 <= rd_ptr_g` and `rs2 <= rs1` every cycle. No logic sits between the input and `rs1`.
- **Reset** (`rst_n=0` at an edge):
  - `wr_bin`, `wr_ptr_g`, `rs1`, `rs2` and `full` go to 0.
  - `wr_addr`, `wr_level` and `wr_ack` therefore read 0 after the edge.
  - Reset overrides a simultaneous `wr_en`. Reset mid-burst discards the pointer; no partial state is kept.
- **Conservative-full guarantee:** a read-pointer advance can only clear `full` late, never early. Under stable `rd_ptr_g`, `full` never asserts falsely.

## Timing
- **Write path:** accepted write at edge k gives the updated `wr_addr`, `wr_ptr_g` and `wr_level` after edge k. `full` reflects that write after edge k as well.
- **Read path:** a `rd_ptr_g` change sampled at edge k appears in `rs2` after edge k+1.
  - `wr_level` updates after edge k+1.
  - `full` deasserts after edge k+2.
- **Back-to-back writes:** throughput is 1 write per cycle until full.
- **Simultaneous events:** a write and a read-pointer change in the same cycle are handled independently. `full` is computed from the post-write `wr_g_next` and the current `rs2`.

## Test plan
- **Reset:** n=2, `rst_n=0` for 2 cycles with `wr_en=1` → all outputs 0. Release → `wr_ack=1` immediately.
- **Fill to full:** n=2, `rd_ptr_g=000`, 4 consecutive writes.
  - `wr_ptr_g` sequence is 001, 011, 010, 110 and `wr_addr` is 1, 2, 3, 0.
  - `full=1` after the 4th edge and `wr_level=4`.
  - A 5th `wr_en` gives `wr_ack=0` and the pointers hold.
- **Drain latency:** from the full state, set `rd_ptr_g=001` at edge k.
  - `wr_level=3` after edge k+1.
  - `full=0` after edge k+2.
  - The next write is accepted and makes `wr_ptr_g=111`.
- **Wrap:** n=2, `rd_ptr_g` tracks `wr_ptr_g` with lag 1, 20 writes → `wr_ptr_g` passes 100 → 000 correctly, `full` never asserts, and `wr_level` stays ≤ 2.
- **Simultaneous write and read at full−1:** n=4, level 15. Write accepted on the same edge that `rd_ptr_g` advances → `full=1` for 2 cycles, then 0. `wr_level` goes 16 → 15.
- **Reset mid-burst:** n=4, after 7 writes assert `rst_n=0` for one edge with `wr_en=1` → `wr_ptr_g=0` and `full=0`. The next write produces `wr_addr=1`.

Source files
------------

// File: rtl/fifo_wptr_full_n.sv
// Write-side pointer and full-flag generator for an async FIFO: binary write
// pointer, registered Gray pointer for the read domain, synchronized read pointer.
module fifo_wptr_full_n #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [n:0]   rd_ptr_g,
  output logic         wr_ack,
  output logic [n-1:0] wr_addr,
  output logic [n:0]   wr_ptr_g,
  output logic         full,
  output logic [n:0]   wr_level
);

  logic [n:0] wr_bin;
  logic [n:0] wr_bin_next;
  logic [n:0] wr_g_next;
  logic [n:0] rs1;
  logic [n:0] rs2;
  logic [n:0] rd_bin_s;
  logic [n:0] full_mask;

  // Reset overrides a simultaneous write request, so no acknowledge during reset.
  assign wr_ack      = wr_en & ~full & rst_n;
  assign wr_bin_next = wr_bin + {{n{1'b0}}, wr_ack};
  assign wr_g_next   = wr_bin_next ^ (wr_bin_next >> 1);

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  always_comb begin
    full_mask        = '0;
    full_mask[n]     = 1'b1;
    full_mask[n-1]   = 1'b1;
  end

  always_comb begin
    rd_bin_s = '0;
    for (int i = 0; i <= n; i++) begin
      rd_bin_s[i] = ^(rs2 >> i);
    end
  end

  assign wr_addr  = wr_bin[n-1:0];
  assign wr_level = wr_bin - rd_bin_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bin   <= '0;
      wr_ptr_g <= '0;
      rs1      <= '0;
      rs2      <= '0;
      full     <= 1'b0;
    end else begin
      wr_bin   <= wr_bin_next;
      wr_ptr_g <= wr_g_next;
      rs1      <= rd_ptr_g;
      rs2      <= rs1;
      full     <= (wr_g_next == (rs2 ^ full_mask));
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full_n.sv
// Self-checking bench for fifo_wptr_full_n: directed scenarios on n=2 and n=4
// instances, then randomized traffic on n=4 against a count-based model.
module tb_fifo_wptr_full_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // n=2 instance
  logic       rst2_n, wr_en2;
  logic [2:0] rd2;
  logic       wr_ack2, full2;
  logic [1:0] wr_addr2;
  logic [2:0] wr_ptr_g2, level2;

  // n=4 instance
  logic       rst4_n, wr_en4;
  logic [4:0] rd4;
  logic       wr_ack4, full4;
  logic [3:0] wr_addr4;
  logic [4:0] wr_ptr_g4, level4;

  fifo_wptr_full_n #(.n(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .wr_en(wr_en2), .rd_ptr_g(rd2),
    .wr_ack(wr_ack2), .wr_addr(wr_addr2), .wr_ptr_g(wr_ptr_g2),
    .full(full2), .wr_level(level2)
  );

  fifo_wptr_full_n #(.n(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .wr_en(wr_en4), .rd_ptr_g(rd4),
    .wr_ack(wr_ack4), .wr_addr(wr_addr4), .wr_ptr_g(wr_ptr_g4),
    .full(full4), .wr_level(level4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Advance one edge; inputs are driven at negedge and outputs sampled at negedge.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) @(negedge clk);
  endtask

  int exp_g[4]    = '{1, 3, 2, 6};
  int exp_addr[4] = '{1, 2, 3, 0};

  int m_wr, m_full, rd_true, rd_d1, rd_d2, nw;
  bit do_rst, we, acc;

  initial begin
    rst2_n = 1'b0; wr_en2 = 1'b1; rd2 = '0;
    rst4_n = 1'b0; wr_en4 = 1'b0; rd4 = '0;
    @(negedge clk);

    // ---------------- n=2: reset with wr_en held high ----------------
    applyStimulus(2);
    checkOutput("rst2_ack",   int'(wr_ack2),   0);
    checkOutput("rst2_g",     int'(wr_ptr_g2), 0);
    checkOutput("rst2_full",  int'(full2),     0);
    checkOutput("rst2_addr",  int'(wr_addr2),  0);
    checkOutput("rst2_level", int'(level2),    0);
    rst2_n = 1'b1;
    #1;
    checkOutput("rel2_ack", int'(wr_ack2), 1);

    // ---------------- n=2: fill to full ----------------
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("fill_g%0d", i),    int'(wr_ptr_g2), exp_g[i]);
      checkOutput($sformatf("fill_addr%0d", i), int'(wr_addr2),  exp_addr[i]);
    end
    checkOutput("fill_full",  int'(full2),  1);
    checkOutput("fill_level", int'(level2), 4);
    #1;
    checkOutput("fill_ack5", int'(wr_ack2), 0);
    applyStimulus(1);
    checkOutput("fill_hold_g",    int'(wr_ptr_g2), 6);
    checkOutput("fill_hold_addr", int'(wr_addr2),  0);

    // ---------------- n=2: drain latency ----------------
    wr_en2 = 1'b0; rd2 = 3'b001;
    applyStimulus(1);
    checkOutput("drain_k_full", int'(full2), 1);
    applyStimulus(1);
    checkOutput("drain_k1_level", int'(level2), 3);
    checkOutput("drain_k1_full",  int'(full2),  1);
    applyStimulus(1);
    checkOutput("drain_k2_full", int'(full2), 0);
    wr_en2 = 1'b1;
    #1;
    checkOutput("drain_ack", int'(wr_ack2), 1);
    applyStimulus(1);
    checkOutput("drain_g", int'(wr_ptr_g2), 7);
    wr_en2 = 1'b0;

    // ---------------- n=2: wrap with reader lagging one cycle ----------------
    rst2_n = 1'b0; rd2 = '0;
    applyStimulus(1);
    rst2_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      rd2 = 3'(gray((j - 1) % 8));
      wr_en2 = 1'b1;
      applyStimulus(1);
      checkOutput($sformatf("wrap_g%0d", j),     int'(wr_ptr_g2), gray(j % 8));
      checkOutput($sformatf("wrap_full%0d", j),  int'(full2),     0);
      checkOutput($sformatf("wrap_level%0d", j), int'(level2),    (j < 2) ? j : 2);
    end
    wr_en2 = 1'b0;

    // ---------------- n=4: simultaneous write and read at full-1 ----------------
    rst4_n = 1'b1; rd4 = '0; wr_en4 = 1'b1;
    applyStimulus(15);
    checkOutput("sim_level15", int'(level4), 15);
    checkOutput("sim_full15",  int'(full4),  0);
    rd4 = 5'(gray(1));
    applyStimulus(1);
    wr_en4 = 1'b0;
    checkOutput("sim_k_full",  int'(full4),  1);
    checkOutput("sim_k_level", int'(level4), 16);
    applyStimulus(1);
    checkOutput("sim_k1_full",  int'(full4),  1);
    checkOutput("sim_k1_level", int'(level4), 15);
    applyStimulus(1);
    checkOutput("sim_k2_full", int'(full4), 0);

    // ---------------- n=4: reset mid-burst ----------------
    rst4_n = 1'b0; rd4 = '0;
    applyStimulus(2);
    rst4_n = 1'b1; wr_en4 = 1'b1;
    applyStimulus(7);
    checkOutput("burst_addr7", int'(wr_addr4), 7);
    rst4_n = 1'b0;
    applyStimulus(1);
    checkOutput("burst_rst_g",    int'(wr_ptr_g4), 0);
    checkOutput("burst_rst_full", int'(full4),     0);
    rst4_n = 1'b1;
    applyStimulus(1);
    checkOutput("burst_next_addr", int'(wr_addr4), 1);
    wr_en4 = 1'b0;

    // ---------------- n=4: randomized traffic vs count model ----------------
    rst4_n = 1'b0; rd4 = '0;
    applyStimulus(2);
    rst4_n = 1'b1;
    m_wr = 0; m_full = 0; rd_true = 0; rd_d1 = 0; rd_d2 = 0;
    for (int t = 0; t < 500; t++) begin
      checkOutput("rnd_g",     int'(wr_ptr_g4), gray(m_wr));
      checkOutput("rnd_addr",  int'(wr_addr4),  m_wr % 16);
      checkOutput("rnd_full",  int'(full4),     m_full);
      checkOutput("rnd_level", int'(level4),    (m_wr - rd_d2) & 31);
      do_rst = ($urandom_range(0, 149) == 0);
      we     = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 4 && ((m_wr - rd_true) & 31) != 0)
        rd_true = (rd_true + 1) & 31;
      rd4    = 5'(gray(rd_true));
      rst4_n = !do_rst;
      wr_en4 = we;
      #1;
      checkOutput("rnd_ack", int'(wr_ack4), int'(we && m_full == 0 && !do_rst));
      @(posedge clk);
      if (do_rst) begin
        m_wr = 0; m_full = 0; rd_d1 = 0; rd_d2 = 0; rd_true = 0;
      end else begin
        acc    = we && (m_full == 0);
        nw     = (m_wr + int'(acc)) & 31;
        m_full = (((nw - rd_d2) & 31) == 16) ? 1 : 0;
        rd_d2  = rd_d1;
        rd_d1  = rd_true;
        m_wr   = nw;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
